// File: rtl/jt03_mixer_if.sv
// Sample bus between the jt03 sound core / host controls and the stereo mixer.
interface jt03_mixer_if;
  logic [7:0]  psg_A;
  logic [7:0]  psg_B;
  logic [7:0]  psg_C;
  logic [15:0] fm_snd;
  logic        snd_sample;
  logic [7:0]  fm_vol;
  logic [7:0]  psg_vol;
  logic [1:0]  pan_mode;
  logic        overrun_clr;
  logic [15:0] snd_left;
  logic [15:0] snd_right;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  modport master (
    output psg_A, psg_B, psg_C, fm_snd, snd_sample, fm_vol, psg_vol, pan_mode, overrun_clr,
    input  snd_left, snd_right, out_valid, busy, overrun
  );

  modport slave (
    input  psg_A, psg_B, psg_C, fm_snd, snd_sample, fm_vol, psg_vol, pan_mode, overrun_clr,
    output snd_left, snd_right, out_valid, busy, overrun
  );
endinterface

// File: rtl/jt03_mixer.sv
// Stereo mixer for jt03: latches one FM + three PSG samples per strobe edge and
// accumulates them through a single shared multiplier with volume and panning.
module jt03_mixer #(
  parameter int PSG_SHIFT = 6,
  parameter int GAIN_FRAC = 7
) (
  input  logic         clk,
  input  logic         rst,
  jt03_mixer_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_FM, S_A, S_B, S_C, S_SAT} state_t;

  state_t             state_q, state_d;
  logic               hist_q, hist_d;
  logic [7:0]         psg_a_q, psg_a_d, psg_b_q, psg_b_d, psg_c_q, psg_c_d;
  logic signed [15:0] fm_q, fm_d;
  logic [7:0]         fm_vol_q, fm_vol_d, psg_vol_q, psg_vol_d;
  logic [1:0]         pan_q, pan_d;
  logic signed [26:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0]        left_q, left_d, right_q, right_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic               trig;
  logic [7:0]         psg_sel;
  logic [15:0]        psg_ext;
  logic signed [15:0] src;
  logic [7:0]         vol_sel;
  logic signed [24:0] prod;
  logic signed [26:0] full, half, add_l, add_r;

  function automatic logic [15:0] sat16(input logic signed [26:0] v);
    if (v > 27'sd32767)       return 16'h7fff;
    else if (v < -27'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  assign trig = bus.snd_sample & ~hist_q;

  // Shared multiplier: operand pair is chosen by the current FSM step.
  always_comb begin
    psg_sel = psg_a_q;
    case (state_q)
      S_B:     psg_sel = psg_b_q;
      S_C:     psg_sel = psg_c_q;
      default: psg_sel = psg_a_q;
    endcase
    psg_ext = {8'd0, psg_sel} << PSG_SHIFT;
    if (state_q == S_FM) begin
      src     = fm_q;
      vol_sel = fm_vol_q;
    end else begin
      src     = $signed(psg_ext);
      vol_sel = psg_vol_q;
    end
    prod = 25'(src) * 25'($signed({1'b0, vol_sel}));
    full = 27'(prod);
    half = full >>> 1;
  end

  // Panning: ABC puts B in the centre, ACB puts C in the centre, mono sends all to both.
  always_comb begin
    add_l = '0;
    add_r = '0;
    case (state_q)
      S_FM: begin add_l = full; add_r = full; end
      S_A: begin
        add_l = full;
        add_r = pan_q[1] ? full : 27'sd0;
      end
      S_B: begin
        if (pan_q[1])       begin add_l = full; add_r = full; end
        else if (pan_q[0])  begin add_r = full; end
        else                begin add_l = half; add_r = half; end
      end
      S_C: begin
        if (pan_q[1])       begin add_l = full; add_r = full; end
        else if (pan_q[0])  begin add_l = half; add_r = half; end
        else                begin add_r = full; end
      end
      default: begin add_l = '0; add_r = '0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = bus.snd_sample;
    psg_a_d   = psg_a_q;
    psg_b_d   = psg_b_q;
    psg_c_d   = psg_c_q;
    fm_d      = fm_q;
    fm_vol_d  = fm_vol_q;
    psg_vol_d = psg_vol_q;
    pan_d     = pan_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          psg_a_d   = bus.psg_A;
          psg_b_d   = bus.psg_B;
          psg_c_d   = bus.psg_C;
          fm_d      = $signed(bus.fm_snd);
          fm_vol_d  = bus.fm_vol;
          psg_vol_d = bus.psg_vol;
          pan_d     = bus.pan_mode;
          acc_l_d   = '0;
          acc_r_d   = '0;
          state_d   = S_FM;
        end
      end
      S_FM, S_A, S_B, S_C: begin
        acc_l_d = acc_l_q + add_l;
        acc_r_d = acc_r_q + add_r;
        case (state_q)
          S_FM:    state_d = S_A;
          S_A:     state_d = S_B;
          S_B:     state_d = S_C;
          default: state_d = S_SAT;
        endcase
      end
      S_SAT: begin
        left_d  = sat16(acc_l_q >>> GAIN_FRAC);
        right_d = sat16(acc_r_q >>> GAIN_FRAC);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new edge while busy is dropped but recorded; it beats a same-cycle clear.
    if (trig && state_q != S_IDLE) overrun_d = 1'b1;
    else if (bus.overrun_clr)      overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hist_q    <= 1'b1;
      psg_a_q   <= '0;
      psg_b_q   <= '0;
      psg_c_q   <= '0;
      fm_q      <= '0;
      fm_vol_q  <= '0;
      psg_vol_q <= '0;
      pan_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      psg_a_q   <= psg_a_d;
      psg_b_q   <= psg_b_d;
      psg_c_q   <= psg_c_d;
      fm_q      <= fm_d;
      fm_vol_q  <= fm_vol_d;
      psg_vol_q <= psg_vol_d;
      pan_q     <= pan_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.snd_left  = left_q;
  assign bus.snd_right = right_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_jt03_mixer.sv
// Self-checking bench for jt03_mixer: hand-derived vectors, multi-cycle corner
// sequences and randomized samples compared against an arithmetic mix model.
module tb_jt03_mixer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  jt03_mixer_if bus ();

  jt03_mixer #(.PSG_SHIFT(6), .GAIN_FRAC(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a, b, c;
    logic [15:0] fm;
    logic [7:0]  fv, pv;
    logic [1:0]  pan;
    int          exp_l, exp_r;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int a, input int b, input int c, input int fm,
                              input int fv, input int pv, input int pan,
                              input int el, input int er);
    vec_t v;
    v.a = a[7:0]; v.b = b[7:0]; v.c = c[7:0]; v.fm = fm[15:0];
    v.fv = fv[7:0]; v.pv = pv[7:0]; v.pan = pan[1:0];
    v.exp_l = el; v.exp_r = er;
    return v;
  endfunction

  function automatic int clampOut(input int acc);
    int s;
    s = acc >>> 7;
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Mix computed straight from the weighting rules: full weight on a side, or half to both.
  function automatic void mixModel(input vec_t v, output int l, output int r);
    int pf, pa, pb, pc;
    pf = int'($signed(v.fm)) * int'(v.fv);
    pa = int'(v.a) * 64 * int'(v.pv);
    pb = int'(v.b) * 64 * int'(v.pv);
    pc = int'(v.c) * 64 * int'(v.pv);
    case (v.pan)
      2'd0: begin l = pf + pa + (pb >>> 1); r = pf + (pb >>> 1) + pc; end
      2'd1: begin l = pf + pa + (pc >>> 1); r = pf + (pc >>> 1) + pb; end
      default: begin l = pf + pa + pb + pc; r = l; end
    endcase
    l = clampOut(l);
    r = clampOut(r);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveVec(input vec_t v);
    bus.psg_A    = v.a;
    bus.psg_B    = v.b;
    bus.psg_C    = v.c;
    bus.fm_snd   = v.fm;
    bus.fm_vol   = v.fv;
    bus.psg_vol  = v.pv;
    bus.pan_mode = v.pan;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
  endtask

  // One full sample: edge, scramble inputs after latch, then latency/value/pulse checks.
  task automatic applyStimulus(input vec_t v, input string name);
    int lat;
    bus.snd_sample = 1'b0;
    @(negedge clk);
    driveVec(v);
    bus.snd_sample = 1'b1;
    @(negedge clk);
    checkOutput({name, "_busy"}, int'(bus.busy), 1);
    bus.snd_sample = 1'b0;
    bus.psg_A    = 8'($urandom);
    bus.psg_B    = 8'($urandom);
    bus.psg_C    = 8'($urandom);
    bus.fm_snd   = 16'($urandom);
    bus.fm_vol   = 8'($urandom);
    bus.psg_vol  = 8'($urandom);
    bus.pan_mode = 2'($urandom);
    waitValid(lat);
    checkOutput({name, "_latency"}, lat, 5);
    checkOutput({name, "_L"}, int'($signed(bus.snd_left)), v.exp_l);
    checkOutput({name, "_R"}, int'($signed(bus.snd_right)), v.exp_r);
    @(negedge clk);
    checkOutput({name, "_pulse"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    int   lat, pulses, busies, held_l;
    vec_t v;

    rst = 1'b1;
    bus.snd_sample  = 1'b0;
    bus.overrun_clr = 1'b0;
    driveVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_L", int'($signed(bus.snd_left)), 0);
    checkOutput("rst_R", int'($signed(bus.snd_right)), 0);
    checkOutput("rst_valid", int'(bus.out_valid), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_overrun", int'(bus.overrun), 0);

    vecs.push_back(mk(0,   0,   0,   1000,   128, 128, 0, 1000,   1000));
    vecs.push_back(mk(255, 0,   0,   0,      0,   128, 0, 16320,  0));
    vecs.push_back(mk(255, 0,   0,   0,      0,   128, 1, 16320,  0));
    vecs.push_back(mk(255, 0,   0,   0,      0,   128, 2, 16320,  16320));
    vecs.push_back(mk(0,   100, 0,   0,      0,   128, 0, 3200,   3200));
    vecs.push_back(mk(0,   100, 0,   0,      0,   128, 1, 0,      6400));
    vecs.push_back(mk(0,   0,   100, 0,      0,   128, 0, 0,      6400));
    vecs.push_back(mk(0,   100, 0,   0,      0,   128, 3, 6400,   6400));
    vecs.push_back(mk(255, 0,   0,   32767,  255, 255, 2, 32767,  32767));
    vecs.push_back(mk(0,   0,   0,   -32768, 255, 0,   0, -32768, -32768));
    vecs.push_back(mk(0,   0,   0,   -1,     64,  0,   0, -1,     -1));
    vecs.push_back(mk(0,   0,   0,   1,      64,  0,   0, 0,      0));
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: new edge in the very cycle out_valid is high.
    bus.snd_sample = 1'b0;
    @(negedge clk);
    driveVec(mk(0, 0, 0, 500, 128, 0, 0, 0, 0));
    bus.snd_sample = 1'b1;
    @(negedge clk);
    bus.snd_sample = 1'b0;
    waitValid(lat);
    checkOutput("b2b_first_latency", lat, 5);
    checkOutput("b2b_first_L", int'($signed(bus.snd_left)), 500);
    driveVec(mk(0, 0, 0, -700, 128, 0, 0, 0, 0));
    bus.snd_sample = 1'b1;
    @(negedge clk);
    checkOutput("b2b_accept_busy", int'(bus.busy), 1);
    bus.snd_sample = 1'b0;
    waitValid(lat);
    checkOutput("b2b_second_latency", lat, 5);
    checkOutput("b2b_second_L", int'($signed(bus.snd_left)), -700);
    checkOutput("b2b_second_R", int'($signed(bus.snd_right)), -700);
    checkOutput("b2b_overrun", int'(bus.overrun), 0);

    // Overrun: second edge two clocks after the first is dropped and flagged.
    bus.snd_sample = 1'b0;
    @(negedge clk);
    driveVec(mk(0, 0, 0, 1000, 128, 0, 0, 0, 0));
    bus.snd_sample = 1'b1;
    @(negedge clk);
    bus.snd_sample = 1'b0;
    @(negedge clk);
    driveVec(mk(0, 0, 0, 2000, 128, 0, 0, 0, 0));
    bus.snd_sample = 1'b1;
    pulses = 0;
    held_l = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        pulses++;
        held_l = int'($signed(bus.snd_left));
      end
    end
    checkOutput("ovr_pulses", pulses, 1);
    checkOutput("ovr_value", held_l, 1000);
    checkOutput("ovr_flag", int'(bus.overrun), 1);
    bus.snd_sample  = 1'b0;
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    checkOutput("ovr_clear", int'(bus.overrun), 0);
    applyStimulus(mk(0, 0, 0, 1000, 128, 0, 0, 1000, 1000), "ovr_next");
    checkOutput("ovr_next_flag", int'(bus.overrun), 0);

    // Set and clear in the same cycle: set wins.
    bus.snd_sample = 1'b1;
    @(negedge clk);
    bus.snd_sample = 1'b0;
    @(negedge clk);
    bus.snd_sample  = 1'b1;
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    bus.snd_sample  = 1'b0;
    checkOutput("ovr_set_wins", int'(bus.overrun), 1);
    repeat (8) @(negedge clk);

    // Reset during S_B with the strobe held high through release.
    bus.snd_sample = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_L", int'($signed(bus.snd_left)), 0);
    checkOutput("midrst_R", int'($signed(bus.snd_right)), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    pulses = 0;
    busies = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
      if (bus.busy) busies++;
    end
    checkOutput("midrst_no_valid", pulses, 0);
    checkOutput("midrst_no_trigger", busies, 0);
    applyStimulus(mk(0, 0, 100, 0, 0, 128, 1, 3200, 3200), "midrst_next");

    for (int i = 0; i < 40; i++) begin
      int el, er;
      v = mk(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
             int'($urandom), int'($urandom_range(255)), int'($urandom_range(255)),
             int'($urandom_range(3)), 0, 0);
      if (i % 8 == 0) begin
        v.fv = 8'd255;
        v.pv = 8'd255;
      end
      mixModel(v, el, er);
      v.exp_l = el;
      v.exp_r = er;
      applyStimulus(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
